memory_r1_up_3_sel: RTL and testbench

- Timing and selection controller that sits directly upstream of the r1 upper-bank tank 3 delay line.
- Owns the tank's digit and minor-cycle counters: 18 digit slots per minor cycle, 32 minor cycles per 1.152 ms circulation.
- Accepts single-word read/write requests from the store control.
- Generates the r1_up_t3_clr, r1_up_t3_in and r1_up_t3_out gates in exactly the digit slots of the addressed short word (one minor cycle) or long word (two consecutive minor cycles).

---
 rtl/memory_r1_up_3_sel.sv | 160 ++++++++++++++++
 tb/tb_memory_r1_up_3_sel.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_r1_up_3_sel.sv
// Timing and word-selection controller for the r1 upper-bank tank 3 delay line:
// free-running digit/minor counters and clear/inject/read gates for one word.
module memory_r1_up_3_sel #(
  parameter int         DIGITS  = 18,
  parameter int         MINORS  = 32,
  parameter logic [4:0] TANK_ID = 5'd3
) (
  input  logic       r1_clk,
  input  logic       r1_rst_n,
  input  logic       req,
  input  logic [9:0] addr,
  input  logic       wr,
  input  logic       long,
  output logic       ack,
  output logic       busy,
  output logic       r1_up_t3_clr,
  output logic       r1_up_t3_in,
  output logic       r1_up_t3_out,
  output logic [4:0] digit_cnt,
  output logic [4:0] minor_cnt,
  output logic       major_sync
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [4:0] DIGIT_LAST = 5'(DIGITS - 1);
  localparam logic [4:0] MINOR_LAST = 5'(MINORS - 1);

  state_t     r_state;
  logic [4:0] r_digit;
  logic [4:0] r_minor;
  logic [4:0] r_tgt;
  logic       r_wr;
  logic       r_long;
  logic       r_ack;
  logic       r_busy;
  logic       r_clr;
  logic       r_in;
  logic       r_out;
  logic       r_major;

  state_t     w_state_nxt;
  logic [4:0] w_digit_nxt;
  logic [4:0] w_minor_nxt;
  logic       w_digit_wrap;
  logic       w_accept;
  logic [4:0] w_tgt_in;
  logic [4:0] w_last_minor;

  // Next counter values; everything downstream is timed against these.
  always_comb begin
    w_digit_wrap = (r_digit == DIGIT_LAST);
    w_digit_nxt  = r_digit + 5'd1;
    w_minor_nxt  = r_minor;
    if (w_digit_wrap) begin
      w_digit_nxt = 5'd0;
      if (r_minor == MINOR_LAST) begin
        w_minor_nxt = 5'd0;
      end else begin
        w_minor_nxt = r_minor + 5'd1;
      end
    end else begin
      w_minor_nxt = r_minor;
    end
  end

  // Long words live at even addresses, so the second minor cycle is tgt|1 and never wraps.
  always_comb begin
    w_tgt_in     = long ? {addr[4:1], 1'b0} : addr[4:0];
    w_last_minor = r_long ? (r_tgt | 5'd1) : r_tgt;
    w_accept     = 1'b0;
    w_state_nxt  = r_state;
    case (r_state)
      S_IDLE: begin
        if (req && (addr[9:5] == TANK_ID)) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if ((w_digit_nxt == 5'd0) && (w_minor_nxt == r_tgt)) begin
          w_state_nxt = S_XFER;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_XFER: begin
        if (w_digit_wrap && (r_minor == w_last_minor)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_XFER;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge r1_clk or negedge r1_rst_n) begin
    if (!r1_rst_n) begin
      r_digit <= 5'd0;
      r_minor <= 5'd0;
      r_major <= 1'b1;
    end else begin
      r_digit <= w_digit_nxt;
      r_minor <= w_minor_nxt;
      r_major <= (w_digit_nxt == 5'd0) && (w_minor_nxt == 5'd0);
    end
  end

  always_ff @(posedge r1_clk or negedge r1_rst_n) begin
    if (!r1_rst_n) begin
      r_state <= S_IDLE;
      r_tgt   <= 5'd0;
      r_wr    <= 1'b0;
      r_long  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_tgt  <= w_tgt_in;
        r_wr   <= wr;
        r_long <= long;
      end
    end
  end

  // Outputs registered from the next state so they line up exactly with the state register.
  always_ff @(posedge r1_clk or negedge r1_rst_n) begin
    if (!r1_rst_n) begin
      r_ack  <= 1'b0;
      r_busy <= 1'b0;
      r_clr  <= 1'b0;
      r_in   <= 1'b0;
      r_out  <= 1'b0;
    end else begin
      r_ack  <= (w_state_nxt == S_DONE);
      r_busy <= (w_state_nxt != S_IDLE);
      r_clr  <= (w_state_nxt == S_XFER) && r_wr;
      r_in   <= (w_state_nxt == S_XFER) && r_wr;
      r_out  <= (w_state_nxt == S_XFER) && !r_wr;
    end
  end

  assign ack          = r_ack;
  assign busy         = r_busy;
  assign r1_up_t3_clr = r_clr;
  assign r1_up_t3_in  = r_in;
  assign r1_up_t3_out = r_out;
  assign digit_cnt    = r_digit;
  assign minor_cnt    = r_minor;
  assign major_sync   = r_major;

endmodule

// File: tb/tb_memory_r1_up_3_sel.sv
// Bench for memory_r1_up_3_sel: outputs are compared every cycle against a model
// that works from absolute slot time since reset release.
module tb_memory_r1_up_3_sel;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [9:0] addr = 10'd0;
  logic       wr = 1'b0;
  logic       long_i = 1'b0;
  logic       ack, busy, clr, inj, outg, major;
  logic [4:0] digit, minor;
  logic [15:0] obs;
  int         t;
  int         n_vec = 0;
  int         n_err = 0;

  memory_r1_up_3_sel dut (
    .r1_clk(clk), .r1_rst_n(rst_n), .req(req), .addr(addr), .wr(wr), .long(long_i),
    .ack(ack), .busy(busy), .r1_up_t3_clr(clr), .r1_up_t3_in(inj), .r1_up_t3_out(outg),
    .digit_cnt(digit), .minor_cnt(minor), .major_sync(major)
  );

  always #5 clk = ~clk;

  // Slot time: number of counting edges since reset was released.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else        t <= t + 1;
  end

  assign obs = {ack, busy, clr, inj, outg, major, minor, digit};

  // First slot strictly after the acceptance cycle's successor whose position is the target word.
  function automatic int win_start(input int s, input logic [4:0] tgt);
    int w   = s + 2;
    int off = (int'(tgt) * 18 - w) % 576;
    if (off < 0) off += 576;
    return w + off;
  endfunction

  function automatic logic [15:0] model(input int tt, input int s, input int w, input int len,
                                        input logic wr_, input logic act);
    int   d = tt % 18;
    int   m = (tt / 18) % 32;
    logic g = act && (tt >= w) && (tt < w + len);
    logic b = act && (tt > s) && (tt <= w + len);
    logic a = act && (tt == w + len);
    return {a, b, g & wr_, g & wr_, g & ~wr_, (tt % 576) == 0, 5'(m), 5'(d)};
  endfunction

  task automatic wait_slot(input int slot, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      if (t % 576 == slot) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic start_req(input logic [9:0] a, input logic w_, input logic l_, input int slot,
                           output int s, output int w, output int len, output bit ok);
    wait_slot(((slot % 576) + 576) % 576, ok);
    req = 1'b1; addr = a; wr = w_; long_i = l_;
    s   = t;
    w   = win_start(s, l_ ? {a[4:1], 1'b0} : a[4:0]);
    len = l_ ? 36 : 18;
  endtask

  function automatic logic [9:0] rand_addr(input logic [4:0] tank);
    logic [4:0] m = 5'($urandom_range(0, 31));
    return {tank, m};
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if (obs !== 16'h0400) begin n_err++; $display("FAIL reset_hold got %h expected %h", obs, 16'h0400); end
    rst_n = 1'b1;
    while (t < 600) begin
      n_vec++;
      if (obs !== model(t, 0, 0, 0, 1'b0, 1'b0)) begin
        n_err++; $display("FAIL free_run t=%0d got %h expected %h", t, obs, model(t, 0, 0, 0, 1'b0, 1'b0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_short_read();
    int s, w, len; bit ok;
    start_req(10'h065, 1'b0, 1'b0, 2 * 18 + int'($urandom_range(0, 17)), s, w, len, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL short_read slot_wait got timeout expected slot"); end
    while (t <= w + len + 1) begin
      n_vec++;
      if (obs !== model(t, s, w, len, 1'b0, 1'b1)) begin
        n_err++; $display("FAIL short_read t=%0d got %h expected %h", t, obs, model(t, s, w, len, 1'b0, 1'b1));
      end
      if (t == w + len) req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_long_write();
    int s, w, len; bit ok;
    start_req(10'h06B, 1'b1, 1'b1, int'($urandom_range(0, 575)), s, w, len, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL long_write slot_wait got timeout expected slot"); end
    while (t <= w + len + 1) begin
      n_vec++;
      if (obs !== model(t, s, w, len, 1'b1, 1'b1)) begin
        n_err++; $display("FAIL long_write t=%0d got %h expected %h", t, obs, model(t, s, w, len, 1'b1, 1'b1));
      end
      if (t == w + len) req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_same_slot_wait();
    int s, w, len, first; bit ok;
    first = -1;
    start_req(10'h067, 1'b0, 1'b0, 7 * 18 + 3, s, w, len, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL same_slot slot_wait got timeout expected slot"); end
    while (t <= w + len + 1) begin
      n_vec++;
      if (obs !== model(t, s, w, len, 1'b0, 1'b1)) begin
        n_err++; $display("FAIL same_slot t=%0d got %h expected %h", t, obs, model(t, s, w, len, 1'b0, 1'b1));
      end
      if (outg === 1'b1 && first < 0) first = t;
      if (t == w + len) req = 1'b0;
      @(negedge clk);
    end
    n_vec++;
    if (first !== s + 573) begin n_err++; $display("FAIL same_slot_start got %0d expected %0d", first, s + 573); end
  endtask

  task automatic test_wait_bounds();
    for (int k = 0; k < 2; k++) begin
      int s, w, len; bit ok;
      logic [9:0] a = rand_addr(5'd3);
      logic lw = 1'($urandom_range(0, 1));
      logic ww = 1'($urandom_range(0, 1));
      int tslot = int'(lw ? {a[4:1], 1'b0} : a[4:0]) * 18;
      start_req(a, ww, lw, tslot - 2 + k, s, w, len, ok);
      n_vec++;
      if (!ok || (w - s - 1) !== (k == 0 ? 1 : 576)) begin
        n_err++; $display("FAIL wait_bound k=%0d got %0d expected %0d", k, w - s - 1, k == 0 ? 1 : 576);
      end
      while (t <= w + len + 1) begin
        n_vec++;
        if (obs !== model(t, s, w, len, ww, 1'b1)) begin
          n_err++; $display("FAIL wait_bound t=%0d got %h expected %h", t, obs, model(t, s, w, len, ww, 1'b1));
        end
        if (t == w + len) req = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_wrong_tank();
    logic [4:0] tk;
    int t0 = t;
    while (t < t0 + 600) begin
      if ((t - t0) % 50 == 0) begin
        do tk = 5'($urandom_range(0, 31)); while (tk == 5'd3);
        req = 1'b1; addr = rand_addr(tk); wr = 1'($urandom_range(0, 1)); long_i = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      n_vec++;
      if (obs !== model(t, 0, 0, 0, 1'b0, 1'b0)) begin
        n_err++; $display("FAIL wrong_tank t=%0d got %h expected %h", t, obs, model(t, 0, 0, 0, 1'b0, 1'b0));
      end
    end
    req = 1'b0;
  endtask

  task automatic test_req_toggle();
    int s, w, len; bit ok;
    start_req(rand_addr(5'd3), 1'b1, 1'b0, int'($urandom_range(0, 575)), s, w, len, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL req_toggle slot_wait got timeout expected slot"); end
    while (t <= w + len + 1) begin
      n_vec++;
      if (obs !== model(t, s, w, len, 1'b1, 1'b1)) begin
        n_err++; $display("FAIL req_toggle t=%0d got %h expected %h", t, obs, model(t, s, w, len, 1'b1, 1'b1));
      end
      if (t > s && t < w + len) begin
        req = 1'($urandom_range(0, 1)); addr = rand_addr(5'($urandom_range(2, 4)));
        wr = 1'($urandom_range(0, 1)); long_i = 1'($urandom_range(0, 1));
      end
      if (t == w + len) req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int s, w, len, s2, w2, len2; bit ok;
    logic [9:0] a2 = rand_addr(5'd3);
    logic l2 = 1'($urandom_range(0, 1));
    logic w2r = 1'($urandom_range(0, 1));
    start_req(rand_addr(5'd3), 1'b0, 1'b1, int'($urandom_range(0, 575)), s, w, len, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL back_to_back slot_wait got timeout expected slot"); end
    while (t <= w + len) begin
      n_vec++;
      if (obs !== model(t, s, w, len, 1'b0, 1'b1)) begin
        n_err++; $display("FAIL b2b_first t=%0d got %h expected %h", t, obs, model(t, s, w, len, 1'b0, 1'b1));
      end
      if (t == w + len) begin addr = a2; wr = w2r; long_i = l2; end
      @(negedge clk);
    end
    s2 = t; len2 = l2 ? 36 : 18;
    w2 = win_start(s2, l2 ? {a2[4:1], 1'b0} : a2[4:0]);
    while (t <= w2 + len2 + 1) begin
      n_vec++;
      if (obs !== model(t, s2, w2, len2, w2r, 1'b1)) begin
        n_err++; $display("FAIL b2b_second t=%0d got %h expected %h", t, obs, model(t, s2, w2, len2, w2r, 1'b1));
      end
      if (t == w2 + len2) req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_in_xfer();
    int s, w, len; bit ok;
    start_req(rand_addr(5'd3), 1'b1, 1'b0, int'($urandom_range(0, 575)), s, w, len, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL reset_xfer slot_wait got timeout expected slot"); end
    while (t < w + 9) begin
      n_vec++;
      if (obs !== model(t, s, w, len, 1'b1, 1'b1)) begin
        n_err++; $display("FAIL reset_xfer_pre t=%0d got %h expected %h", t, obs, model(t, s, w, len, 1'b1, 1'b1));
      end
      @(negedge clk);
    end
    n_vec++;
    if (obs !== model(t, s, w, len, 1'b1, 1'b1)) begin
      n_err++; $display("FAIL reset_xfer_digit9 got %h expected %h", obs, model(t, s, w, len, 1'b1, 1'b1));
    end
    rst_n = 1'b0; req = 1'b0;
    #1;
    n_vec++;
    if (obs !== 16'h0400) begin n_err++; $display("FAIL reset_xfer_async got %h expected %h", obs, 16'h0400); end
    @(negedge clk);
    rst_n = 1'b1;
    while (t < 40) begin
      n_vec++;
      if (obs !== model(t, 0, 0, 0, 1'b0, 1'b0)) begin
        n_err++; $display("FAIL reset_xfer_after t=%0d got %h expected %h", t, obs, model(t, 0, 0, 0, 1'b0, 1'b0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      int s, w, len; bit ok;
      logic lw = 1'($urandom_range(0, 1));
      logic ww = 1'($urandom_range(0, 1));
      start_req(rand_addr(5'd3), ww, lw, int'($urandom_range(0, 575)), s, w, len, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL random slot_wait got timeout expected slot"); end
      while (t <= w + len + 1) begin
        n_vec++;
        if (obs !== model(t, s, w, len, ww, 1'b1)) begin
          n_err++; $display("FAIL random k=%0d t=%0d got %h expected %h", k, t, obs, model(t, s, w, len, ww, 1'b1));
        end
        if (t == w + len) req = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_read();
    test_long_write();
    test_same_slot_wait();
    test_wait_bounds();
    test_wrong_tank();
    test_req_toggle();
    test_back_to_back();
    test_reset_in_xfer();
    test_short_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
